// File: rtl/fill_sequencer_if.sv
// Command and write-port bundle for fill_sequencer.
// The slave side is the sequencer; the master side is the config master plus array observer.
interface fill_sequencer_if #(
  parameter int WIDTH  = 40,
  parameter int ADDR_W = 4,
  parameter int PAT_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [PAT_W-1:0]  cmd_pat;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_mode, cmd_pat, cmd_base, cmd_len,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_pat, cmd_base, cmd_len,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/fill_sequencer.sv
// Block-fill write sequencer: one accepted command writes LEN consecutive words
// (wrapping address) with a constant derived from the mode and pattern.
module fill_sequencer #(
  parameter int WIDTH  = 40,
  parameter int ADDR_W = 4,
  parameter int PAT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fill_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned       DEPTH_I = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W+1)'(DEPTH_I);

  // Fill word: zeros, ones, pattern repeated from the LSB, or pattern sign-extended.
  function automatic logic [WIDTH-1:0] fill_word(input logic [1:0] mode,
                                                 input logic [PAT_W-1:0] pat);
    logic [WIDTH-1:0] w;
    w = {WIDTH{1'b0}};
    case (mode)
      2'b00: w = {WIDTH{1'b0}};
      2'b01: w = {WIDTH{1'b1}};
      2'b10: begin
        for (int i = 0; i < WIDTH; i++) begin
          w[i] = pat[i % PAT_W];
        end
      end
      2'b11: begin
        for (int i = 0; i < WIDTH; i++) begin
          w[i] = pat[(i < PAT_W) ? i : (PAT_W - 1)];
        end
      end
      default: w = {WIDTH{1'b0}};
    endcase
    return w;
  endfunction

  state_t            state_r, state_s;
  logic              wr_en_r, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
  logic [WIDTH-1:0]  wr_data_r, wr_data_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [ADDR_W:0]   remain_r, remain_s;
  logic [ADDR_W:0]   len_eff_s;

  assign len_eff_s = (bus.cmd_len > DEPTH) ? DEPTH : bus.cmd_len;

  // Next-state and next-output decode
  always_comb begin
    state_s   = state_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    remain_s  = remain_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          wr_data_s = fill_word(bus.cmd_mode, bus.cmd_pat);
          busy_s    = 1'b1;
          // A zero-length command skips FILL and reports completion directly.
          if (len_eff_s == {(ADDR_W+1){1'b0}}) begin
            done_s  = 1'b1;
            state_s = DONE;
          end else begin
            wr_en_s   = 1'b1;
            wr_addr_s = bus.cmd_base;
            remain_s  = len_eff_s - (ADDR_W+1)'(1'b1);
            state_s   = FILL;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      FILL: begin
        if (remain_r != {(ADDR_W+1){1'b0}}) begin
          wr_en_s   = 1'b1;
          wr_addr_s = wr_addr_r + ADDR_W'(1'b1);
          remain_s  = remain_r - (ADDR_W+1)'(1'b1);
        end else begin
          done_s  = 1'b1;
          state_s = DONE;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      remain_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      state_r   <= state_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      remain_r  <= remain_s;
    end
  end

  assign bus.cmd_ready = rst_n && (state_r == IDLE);
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_fill_sequencer.sv
// Randomised and directed bench for fill_sequencer against a behavioural model.
module tb_fill_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  fill_sequencer_if #(.WIDTH(40), .ADDR_W(4), .PAT_W(4)) bus ();
  fill_sequencer_if #(.WIDTH(3),  .ADDR_W(4), .PAT_W(4)) bus3 ();

  fill_sequencer #(.WIDTH(40), .ADDR_W(4), .PAT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fill_sequencer #(.WIDTH(3), .ADDR_W(4), .PAT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected word from the fill rules, using plain integer arithmetic.
  function automatic longint unsigned model_data(input int w, input int mode, input int pat);
    longint unsigned mask;
    longint unsigned r;
    longint          sv;
    mask = (64'd1 << w) - 64'd1;
    r = 64'd0;
    case (mode)
      0: r = 64'd0;
      1: r = mask;
      2: begin
        for (int k = 0; k < w; k += 4) r = r | (longint'(pat) << k);
        r = r & mask;
      end
      3: begin
        sv = (pat >= 8) ? longint'(pat) - 64'sd16 : longint'(pat);
        r = longint'(sv) & mask;
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] mode, input logic [3:0] pat, input logic [3:0] base,
                         input logic [4:0] len, input bit hold_next, input logic [1:0] n_mode,
                         input logic [3:0] n_pat, input logic [3:0] n_base, input logic [4:0] n_len,
                         output int acc_cyc);
    int len_eff;
    int waited;
    longint unsigned exp;
    len_eff = (len > 5'd16) ? 16 : int'(len);
    exp = model_data(40, int'(mode), int'(pat));
    bus.cmd_mode  = mode;
    bus.cmd_pat   = pat;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check_val("accept_timeout", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    tick();
    acc_cyc = cyc;
    if (hold_next) begin
      bus.cmd_mode = n_mode;
      bus.cmd_pat  = n_pat;
      bus.cmd_base = n_base;
      bus.cmd_len  = n_len;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (int i = 0; i < len_eff; i++) begin
      check_val("fill_wr_en", 64'(bus.wr_en), 64'd1);
      check_val("fill_addr", 64'(bus.wr_addr), 64'((int'(base) + i) % 16));
      check_val("fill_data", 64'(bus.wr_data), exp);
      check_val("fill_done", 64'(bus.done), 64'd0);
      check_val("fill_busy", 64'(bus.busy), 64'd1);
      check_val("fill_ready", 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    check_val("done_wr_en", 64'(bus.wr_en), 64'd0);
    check_val("done_pulse", 64'(bus.done), 64'd1);
    check_val("done_busy", 64'(bus.busy), 64'd1);
    check_val("done_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    check_val("idle_done", 64'(bus.done), 64'd0);
    check_val("idle_busy", 64'(bus.busy), 64'd0);
    check_val("idle_wr_en", 64'(bus.wr_en), 64'd0);
    check_val("idle_ready", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;
    int gap;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid  = 1'b0; bus.cmd_mode  = 2'b00; bus.cmd_pat  = 4'd0;
    bus.cmd_base   = 4'd0; bus.cmd_len   = 5'd0;
    bus3.cmd_valid = 1'b0; bus3.cmd_mode = 2'b00; bus3.cmd_pat = 4'd0;
    bus3.cmd_base  = 4'd0; bus3.cmd_len  = 5'd0;

    repeat (3) tick();
    check_val("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check_val("rst_addr", 64'(bus.wr_addr), 64'd0);
    check_val("rst_data", 64'(bus.wr_data), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_ready", 64'(bus.cmd_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("rel_ready", 64'(bus.cmd_ready), 64'd1);

    run_cmd(2'b01, 4'b0000, 4'd3, 5'd2, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b10, 4'b1010, 4'd0, 5'd1, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b11, 4'b1010, 4'd6, 5'd1, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b11, 4'b0101, 4'd8, 5'd1, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b00, 4'b1111, 4'd2, 5'd3, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b10, 4'b0110, 4'd14, 5'd4, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b11, 4'b1001, 4'd5, 5'd16, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b01, 4'b0000, 4'd7, 5'd25, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    run_cmd(2'b00, 4'b0000, 4'd9, 5'd0, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);

    // Reset in the middle of a fill: nothing completes, outputs clear.
    bus.cmd_mode = 2'b01; bus.cmd_pat = 4'd0; bus.cmd_base = 4'd10; bus.cmd_len = 5'd8;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check_val("mid_w0_addr", 64'(bus.wr_addr), 64'd10);
    tick();
    check_val("mid_w1_en", 64'(bus.wr_en), 64'd1);
    check_val("mid_w1_addr", 64'(bus.wr_addr), 64'd11);
    rst_n = 1'b0;
    tick();
    check_val("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
    check_val("mid_rst_done", 64'(bus.done), 64'd0);
    check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_val("mid_rst_addr", 64'(bus.wr_addr), 64'd0);
    check_val("mid_rst_data", 64'(bus.wr_data), 64'd0);
    check_val("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    check_val("mid_rst_done2", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    #1;
    check_val("mid_rel_ready", 64'(bus.cmd_ready), 64'd1);
    run_cmd(2'b10, 4'b0011, 4'd1, 5'd3, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);

    // Back-to-back: second command held valid during a len-3 fill.
    run_cmd(2'b01, 4'd0, 4'd4, 5'd3, 1'b1, 2'b10, 4'b1100, 4'd12, 5'd2, acc1);
    run_cmd(2'b10, 4'b1100, 4'd12, 5'd2, 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc2);
    check_val("b2b_spacing", 64'(acc2 - acc1), 64'd5);

    // Narrow instance: pattern wider than the word keeps the low bits.
    bus3.cmd_mode = 2'b10; bus3.cmd_pat = 4'b1101; bus3.cmd_base = 4'd0; bus3.cmd_len = 5'd1;
    bus3.cmd_valid = 1'b1;
    tick();
    bus3.cmd_valid = 1'b0;
    check_val("w3_rep_en", 64'(bus3.wr_en), 64'd1);
    check_val("w3_rep_data", 64'(bus3.wr_data), model_data(3, 2, 13));
    repeat (2) tick();
    bus3.cmd_mode = 2'b11; bus3.cmd_pat = 4'b0011;
    bus3.cmd_valid = 1'b1;
    tick();
    bus3.cmd_valid = 1'b0;
    check_val("w3_sx_data", 64'(bus3.wr_data), model_data(3, 3, 3));
    repeat (2) tick();

    for (int n = 0; n < 30; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check_val("gap_wr_en", 64'(bus.wr_en), 64'd0);
        check_val("gap_done", 64'(bus.done), 64'd0);
      end
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              5'($urandom_range(0, 20)), 1'b0, 2'b00, 4'd0, 4'd0, 5'd0, acc1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
